// File: rtl/rv32i_types.sv
// Shared types for the memory-side blocks: arbiter FSM encoding and default line width.
package rv32i_types;

  localparam int unsigned SLineDefault = 256;

  typedef enum logic [1:0] {
    StIdle,
    StGrantI,
    StGrantD,
    StDone
  } arbiter_state_t;

endpackage

// File: rtl/cache_arbiter.sv
// Round-robin arbiter between I-cache and D-cache line requests onto one physical memory port.
module cache_arbiter
  import rv32i_types::*;
#(
  parameter int unsigned width  = 32,
  parameter int unsigned s_line = SLineDefault
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              icache_pmem_read_i,
  input  logic [width-1:0]  icache_pmem_address_i,
  output logic [s_line-1:0] icache_pmem_rdata_o,
  output logic              icache_pmem_resp_o,
  input  logic              dcache_pmem_read_i,
  input  logic              dcache_pmem_write_i,
  input  logic [width-1:0]  dcache_pmem_address_i,
  input  logic [s_line-1:0] dcache_pmem_wdata_i,
  output logic [s_line-1:0] dcache_pmem_rdata_o,
  output logic              dcache_pmem_resp_o,
  output logic              pmem_read_o,
  output logic              pmem_write_o,
  output logic [width-1:0]  pmem_address_o,
  output logic [s_line-1:0] pmem_wdata_o,
  input  logic [s_line-1:0] pmem_rdata_i,
  input  logic              pmem_resp_i
);

  arbiter_state_t state_q, state_d;
  logic           last_grant_q, last_grant_d;  // 0 = I-cache, 1 = D-cache
  logic           d_req;

  assign d_req               = dcache_pmem_read_i | dcache_pmem_write_i;
  assign icache_pmem_rdata_o = pmem_rdata_i;
  assign dcache_pmem_rdata_o = pmem_rdata_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    last_grant_d       = last_grant_q;
    pmem_read_o        = 1'b0;
    pmem_write_o       = 1'b0;
    pmem_address_o     = '0;
    pmem_wdata_o       = '0;
    icache_pmem_resp_o = 1'b0;
    dcache_pmem_resp_o = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (icache_pmem_read_i && d_req) begin
          state_d = last_grant_q ? StGrantI : StGrantD;
        end else if (icache_pmem_read_i) begin
          state_d = StGrantI;
        end else if (d_req) begin
          state_d = StGrantD;
        end
      end
      StGrantI: begin
        pmem_read_o    = icache_pmem_read_i;
        pmem_address_o = icache_pmem_address_i;
        if (pmem_resp_i) begin
          icache_pmem_resp_o = 1'b1;
          last_grant_d       = 1'b0;
          state_d            = StDone;
        end
      end
      StGrantD: begin
        pmem_read_o    = dcache_pmem_read_i;
        pmem_write_o   = dcache_pmem_write_i;
        pmem_address_o = dcache_pmem_address_i;
        pmem_wdata_o   = dcache_pmem_wdata_i;
        if (pmem_resp_i) begin
          dcache_pmem_resp_o = 1'b1;
          last_grant_d       = 1'b1;
          state_d            = StDone;
        end
      end
      // One dead cycle so the requester can drop its request before re-arbitration.
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  a_i_held: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == StGrantI) |-> icache_pmem_read_i);
  a_d_held: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == StGrantD) |-> d_req);
  a_d_rw_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(dcache_pmem_read_i && dcache_pmem_write_i));

endmodule
